// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
//   Shared constants for the seven-segment scan driver.
//   - SEG_BLANK      : active-low segment pattern with every segment off
//   - HEX_SEG_TABLE  : active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
//   - counter_width(): bits needed to hold any count 0..max_count (minimum 1)
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b0100111,  // c
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  function automatic int counter_width(input int max_count);
    for (int w = 1; w < 32; w++) begin
      if ((max_count >> w) == 0) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/hex_seg_lut.sv
// hex_seg_lut
//   Combinational hex-to-seven-segment decoder for a common-anode display.
//   Ports:
//     nibble  in  4  hex digit to decode
//     seg     out 7  active-low segments {g,f,e,d,c,b,a}
module hex_seg_lut
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Time-multiplexed driver for an N-digit common-anode seven-segment display.
//   Each digit owns a slot of DIGIT_CYCLES clocks; the first BLANK_CYCLES of a
//   slot keep every anode off to avoid ghosting. Inputs are captured once per
//   frame (at the start of digit 0's slot) so a frame never mixes old and new
//   data. All display outputs come straight from flops.
//   Ports:
//     clk          in  1            system clock
//     reset        in  1            asynchronous, active-high
//     value        in  4*NUM_DIGITS packed hex digits, digit 0 = value[3:0]
//     dp_in        in  NUM_DIGITS   decimal point request per digit (1 = lit)
//     digit_en     in  NUM_DIGITS   1 = digit may display, 0 = forced blank
//     lz_blank     in  1            1 = suppress leading zeros
//     blink_mask   in  NUM_DIGITS   1 = digit blinks
//     anode        out NUM_DIGITS   active-low digit select
//     cathode      out 7            active-low segments {g,f,e,d,c,b,a}
//     dp           out 1            active-low decimal point
//     frame_start  out 1            one-cycle pulse as digit 0's slot begins
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              cathode,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int CW = counter_width(DIGIT_CYCLES - 1);
  localparam int IW = counter_width(NUM_DIGITS - 1);
  localparam int BW = counter_width(BLINK_FRAMES - 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BLANK  = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [BW-1:0]           blink_cnt;
  logic [BW-1:0]           blink_cnt_next;
  logic                    phase;
  logic                    phase_next;
  logic                    load_pending;

  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic                    sh_lz;
  logic [NUM_DIGITS-1:0]   sh_blink;

  logic                    capture;
  logic [4*NUM_DIGITS-1:0] eff_value;
  logic [NUM_DIGITS-1:0]   eff_dp;
  logic [NUM_DIGITS-1:0]   eff_en;
  logic                    eff_lz;
  logic [NUM_DIGITS-1:0]   eff_blink;

  logic [NUM_DIGITS-1:0]   lzb;
  logic                    zeros_above;
  logic                    visible;
  logic [3:0]              nibble;
  logic [6:0]              lut_seg;
  logic [NUM_DIGITS-1:0]   anode_next;
  logic [6:0]              cathode_next;
  logic                    dp_next;

  // A frame begins whenever the scan sits at digit 0, count 0. load_pending
  // guarantees the very first cycle after reset also loads fresh inputs.
  assign capture = load_pending | ((cnt == '0) && (idx == '0));

  // During the capture cycle the shadow flops still hold the previous frame,
  // so the output logic looks through to the live inputs; this keeps the
  // first visible cycle of a frame consistent even with no blank time.
  assign eff_value = capture ? value      : sh_value;
  assign eff_dp    = capture ? dp_in      : sh_dp;
  assign eff_en    = capture ? digit_en   : sh_en;
  assign eff_lz    = capture ? lz_blank   : sh_lz;
  assign eff_blink = capture ? blink_mask : sh_blink;

  // Slot counter and digit index: the index advances once per slot wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Blink frame counter: counts frame starts, toggling the phase on wrap.
  always_comb begin
    blink_cnt_next = blink_cnt;
    phase_next     = phase;
    if (capture) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_next = '0;
        phase_next     = ~phase;
      end else begin
        blink_cnt_next = blink_cnt + 1'b1;
      end
    end
  end

  // Shadow registers, blink state and the frame_start pulse all move on the
  // same capture edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_value     <= '0;
      sh_dp        <= '0;
      sh_en        <= '0;
      sh_lz        <= 1'b0;
      sh_blink     <= '0;
      blink_cnt    <= '0;
      phase        <= 1'b0;
      load_pending <= 1'b1;
      frame_start  <= 1'b0;
    end else begin
      blink_cnt    <= blink_cnt_next;
      phase        <= phase_next;
      frame_start  <= capture;
      load_pending <= 1'b0;
      if (capture) begin
        sh_value <= value;
        sh_dp    <= dp_in;
        sh_en    <= digit_en;
        sh_lz    <= lz_blank;
        sh_blink <= blink_mask;
      end
    end
  end

  // Leading-zero mask: walk down from the top digit while every nibble seen
  // so far is zero. Digit 0 is left out so a zero value still shows "0".
  always_comb begin
    lzb         = '0;
    zeros_above = eff_lz;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zeros_above = zeros_above & (eff_value[4*k +: 4] == 4'h0);
      lzb[k]      = zeros_above;
    end
  end

  assign nibble  = eff_value[{idx, 2'b00} +: 4];
  assign visible = eff_en[idx] & ~lzb[idx] & ~(eff_blink[idx] & phase_next);

  hex_seg_lut u_hex_seg_lut (
    .nibble (nibble),
    .seg    (lut_seg)
  );

  // Next display state for the current slot. The anode stays selected for an
  // invisible digit so the scan timing seen on the board never changes.
  always_comb begin
    anode_next   = '1;
    cathode_next = SEG_BLANK;
    dp_next      = 1'b1;
    if (cnt >= CNT_BLANK) begin
      anode_next = ~(NUM_DIGITS'(1) << idx);
    end
    if (visible) begin
      cathode_next = lut_seg;
      dp_next      = ~eff_dp[idx];
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode   <= '1;
      cathode <= SEG_BLANK;
      dp      <= 1'b1;
    end else begin
      anode   <= anode_next;
      cathode <= cathode_next;
      dp      <= dp_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver
//   Directed bench for seven_seg_scan_driver with NUM_DIGITS=4,
//   DIGIT_CYCLES=4, BLANK_CYCLES=1, BLINK_FRAMES=2. A frame is 16 clocks;
//   after reset release, edge t shows frame position p=(t-1)%16,
//   slot p/4, slot cycle p%4 (cycle 0 is the blank cycle).
module tb_seven_seg_scan_driver;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic [3:0]  blink_mask;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        dp;
  logic        frame_start;

  int tests;
  int fails;

  seven_seg_scan_driver #(
    .NUM_DIGITS   (4),
    .DIGIT_CYCLES (4),
    .BLANK_CYCLES (1),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .lz_blank    (lz_blank),
    .blink_mask  (blink_mask),
    .anode       (anode),
    .cathode     (cathode),
    .dp          (dp),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-entered active-low hex table.
  function automatic logic [6:0] exp_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b0100111;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [3:0] sel_anode(input int slot);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << slot);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs, pulse reset, and release it midway between edges.
  task automatic start(input logic [15:0] v, input logic [3:0] d,
                       input logic [3:0] en, input logic lz, input logic [3:0] bm);
    value      = v;
    dp_in      = d;
    digit_en   = en;
    lz_blank   = lz;
    blink_mask = bm;
    reset      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    value = 16'h1234; dp_in = 4'hF; digit_en = 4'hF; lz_blank = 1'b0; blink_mask = 4'h0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (anode !== 4'hF) begin fails++; $display("[TB] FAIL reset_anode got %b want 1111", anode); end
    tests++; if (cathode !== 7'h7F) begin fails++; $display("[TB] FAIL reset_cathode got %b want 1111111", cathode); end
    tests++; if (dp !== 1'b1) begin fails++; $display("[TB] FAIL reset_dp got %b want 1", dp); end
    tests++; if (frame_start !== 1'b0) begin fails++; $display("[TB] FAIL reset_frame_start got %b want 0", frame_start); end
  endtask

  task automatic test_scan();
    int p, slot, c;
    logic [3:0] exp_an;
    start(16'h1234, 4'h0, 4'hF, 1'b0, 4'h0);
    for (int t = 1; t <= 40; t++) begin
      tick();
      p = (t - 1) % 16; slot = p / 4; c = p % 4;
      exp_an = (c == 0) ? 4'hF : sel_anode(slot);
      tests++; if (anode !== exp_an) begin fails++; $display("[TB] FAIL scan_anode t=%0d got %b want %b", t, anode, exp_an); end
      tests++; if (frame_start !== (p == 0)) begin fails++; $display("[TB] FAIL scan_frame_start t=%0d got %b want %b", t, frame_start, p == 0); end
      if (c != 0) begin
        tests++; if (cathode !== exp_seg(value[slot*4 +: 4])) begin fails++; $display("[TB] FAIL scan_cathode t=%0d got %b want %b", t, cathode, exp_seg(value[slot*4 +: 4])); end
        tests++; if (dp !== 1'b1) begin fails++; $display("[TB] FAIL scan_dp t=%0d got %b want 1", t, dp); end
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [6:0] cat_a [4];
    logic       dp_a  [4];
    logic [6:0] cat_b [4];
    logic       dp_b  [4];
    int p, slot, c;
    // 00A0: digits 3,2 blanked (dp off too), digit 1 'A', digit 0 '0'.
    cat_a = '{7'b1000000, 7'b0001000, 7'h7F, 7'h7F};
    dp_a  = '{1'b0, 1'b0, 1'b1, 1'b1};
    // 0000: only digit 0 survives.
    cat_b = '{7'b1000000, 7'h7F, 7'h7F, 7'h7F};
    dp_b  = '{1'b0, 1'b1, 1'b1, 1'b1};
    start(16'h00A0, 4'hF, 4'hF, 1'b1, 4'h0);
    for (int t = 1; t <= 16; t++) begin
      tick();
      p = t - 1; slot = p / 4; c = p % 4;
      if (c != 0) begin
        tests++; if (anode !== sel_anode(slot)) begin fails++; $display("[TB] FAIL lz_anode t=%0d got %b want %b", t, anode, sel_anode(slot)); end
        tests++; if (cathode !== cat_a[slot]) begin fails++; $display("[TB] FAIL lz_cathode t=%0d got %b want %b", t, cathode, cat_a[slot]); end
        tests++; if (dp !== dp_a[slot]) begin fails++; $display("[TB] FAIL lz_dp t=%0d got %b want %b", t, dp, dp_a[slot]); end
      end
    end
    start(16'h0000, 4'hF, 4'hF, 1'b1, 4'h0);
    for (int t = 1; t <= 16; t++) begin
      tick();
      p = t - 1; slot = p / 4; c = p % 4;
      if (c != 0) begin
        tests++; if (cathode !== cat_b[slot]) begin fails++; $display("[TB] FAIL lz_zero_cathode t=%0d got %b want %b", t, cathode, cat_b[slot]); end
        tests++; if (dp !== dp_b[slot]) begin fails++; $display("[TB] FAIL lz_zero_dp t=%0d got %b want %b", t, dp, dp_b[slot]); end
      end
    end
  endtask

  task automatic test_no_tearing();
    logic [6:0] exp_c;
    start(16'h1111, 4'h0, 4'hF, 1'b0, 4'h0);
    for (int t = 1; t <= 32; t++) begin
      tick();
      if (t == 6) value = 16'h2222;
      exp_c = (t <= 16) ? 7'b1111001 : 7'b0100100;
      if (((t - 1) % 4) != 0) begin
        tests++; if (cathode !== exp_c) begin fails++; $display("[TB] FAIL tearing_cathode t=%0d got %b want %b", t, cathode, exp_c); end
      end
    end
  endtask

  task automatic test_blink();
    logic [5:0] dark_pat;
    logic       dark;
    int p, slot, c, f;
    // Phase after each frame start: frames 0..5 -> 0,1,1,0,0,1.
    dark_pat = 6'b100110;
    start(16'h1234, 4'b0001, 4'hF, 1'b0, 4'b0001);
    for (int t = 1; t <= 96; t++) begin
      tick();
      f = (t - 1) / 16; p = (t - 1) % 16; slot = p / 4; c = p % 4;
      dark = dark_pat[f];
      if (c != 0) begin
        if (slot == 0) begin
          tests++; if (cathode !== (dark ? 7'h7F : 7'b0011001)) begin fails++; $display("[TB] FAIL blink_cathode t=%0d got %b want %b", t, cathode, dark ? 7'h7F : 7'b0011001); end
          tests++; if (dp !== dark) begin fails++; $display("[TB] FAIL blink_dp t=%0d got %b want %b", t, dp, dark); end
        end else begin
          tests++; if (cathode !== exp_seg(value[slot*4 +: 4])) begin fails++; $display("[TB] FAIL blink_other_cathode t=%0d got %b want %b", t, cathode, exp_seg(value[slot*4 +: 4])); end
        end
      end
    end
  endtask

  task automatic test_dp_enable();
    logic [6:0] exp_c;
    int p, slot, c;
    // Digit 2 requests its dp but is disabled, so it stays fully dark.
    start(16'h1234, 4'b0100, 4'b1011, 1'b0, 4'h0);
    for (int t = 1; t <= 16; t++) begin
      tick();
      p = t - 1; slot = p / 4; c = p % 4;
      if (c != 0) begin
        exp_c = (slot == 2) ? 7'h7F : exp_seg(value[slot*4 +: 4]);
        tests++; if (anode !== sel_anode(slot)) begin fails++; $display("[TB] FAIL en_anode t=%0d got %b want %b", t, anode, sel_anode(slot)); end
        tests++; if (cathode !== exp_c) begin fails++; $display("[TB] FAIL en_cathode t=%0d got %b want %b", t, cathode, exp_c); end
        tests++; if (dp !== 1'b1) begin fails++; $display("[TB] FAIL en_dp t=%0d got %b want 1", t, dp); end
      end
    end
  endtask

  task automatic test_reset_mid_slot();
    start(16'h1234, 4'b0001, 4'hF, 1'b0, 4'h0);
    repeat (11) tick();
    tests++; if (anode !== 4'b1011) begin fails++; $display("[TB] FAIL mid_pre_anode got %b want 1011", anode); end
    #2 reset = 1'b1;
    #1;
    tests++; if (anode !== 4'hF) begin fails++; $display("[TB] FAIL mid_async_anode got %b want 1111", anode); end
    tests++; if (cathode !== 7'h7F) begin fails++; $display("[TB] FAIL mid_async_cathode got %b want 1111111", cathode); end
    tests++; if (dp !== 1'b1) begin fails++; $display("[TB] FAIL mid_async_dp got %b want 1", dp); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    tests++; if (anode !== 4'hF) begin fails++; $display("[TB] FAIL mid_restart_blank got %b want 1111", anode); end
    tests++; if (frame_start !== 1'b1) begin fails++; $display("[TB] FAIL mid_restart_frame_start got %b want 1", frame_start); end
    tick();
    tests++; if (anode !== 4'b1110) begin fails++; $display("[TB] FAIL mid_restart_anode got %b want 1110", anode); end
    tests++; if (cathode !== 7'b0011001) begin fails++; $display("[TB] FAIL mid_restart_cathode got %b want 0011001", cathode); end
    tests++; if (dp !== 1'b0) begin fails++; $display("[TB] FAIL mid_restart_dp got %b want 0", dp); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    test_reset();
    test_scan();
    test_lz_blank();
    test_no_tearing();
    test_blink();
    test_dp_enable();
    test_reset_mid_slot();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
